// File: rtl/data_bus_ctrl_if.sv
// Load/store bus between the core's LSU (master) and the data bus
// controller (slave). Store and load requests have separate address, size
// and data fields.
interface data_bus_ctrl_if;
    logic        rd;
    logic        wd;
    logic [1:0]  size_in;
    logic [1:0]  size_out;
    logic        sign_out;
    logic [31:0] addr_in;
    logic [31:0] addr_out;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        rvalid;
    logic        ready;
    logic        busy;
    logic        fault;

    modport master (
        output rd, wd, size_in, size_out, sign_out, addr_in, addr_out, data_in,
        input  data_out, rvalid, ready, busy, fault
    );

    modport slave (
        input  rd, wd, size_in, size_out, sign_out, addr_in, addr_out, data_in,
        output data_out, rvalid, ready, busy, fault
    );
endinterface

// File: rtl/data_bus_ctrl.sv
// Data-memory bus controller. It handles byte, half-word and word
// loads/stores to on-chip RAM, and to a small register window that holds
// the sticky fault status and the address of the first fault. Each request
// is registered when it is accepted and completes exactly one cycle later.
module data_bus_ctrl #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] REG_BASE  = 32'h0001_0000
) (
    input  logic           clk,
    input  logic           rst,
    data_bus_ctrl_if.slave bus
);
    localparam int unsigned AW      = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * RAM_WORDS);
    localparam logic [32:0] REG_END = {1'b0, REG_BASE} + 33'd16;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   data_reg;
    logic [1:0]    size_reg;
    logic          sign_reg;
    logic          ready_reg;
    logic          busy_reg;
    logic          rvalid_reg;
    logic          fault_reg;
    logic [31:0]   data_out_reg;
    logic [1:0]    status_reg;
    logic [31:0]   fault_addr_reg;

    logic          ram_hit;
    logic          reg_hit;
    logic          misaligned;
    logic          access_fault;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          ram_we;
    logic [3:0][7:0] rd_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [31:0]   reg_rdata;
    logic [31:0]   rd_result;
    logic [1:0]    status_set;
    logic [1:0]    status_clr;
    logic [1:0]    status_next;

    // Decode the registered request: target, alignment, lane enables and fault.
    always_comb begin
        ram_hit  = ({1'b0, addr_reg} >= {1'b0, RAM_BASE}) && ({1'b0, addr_reg} < RAM_END);
        reg_hit  = ({1'b0, addr_reg} >= {1'b0, REG_BASE}) && ({1'b0, addr_reg} < REG_END);
        lane     = addr_reg[1:0];
        word_idx = addr_reg[AW+1:2] - RAM_BASE[AW+1:2];
        // The register window accepts only aligned word accesses.
        misaligned = (size_reg == 2'b11)
                   || (size_reg == 2'b01 && addr_reg[0])
                   || (size_reg == 2'b10 && addr_reg[1:0] != 2'b00)
                   || (reg_hit && size_reg != 2'b10);
        access_fault = misaligned || (!ram_hit && !reg_hit);

        be    = 4'b1111;
        wdata = data_reg;
        case (size_reg)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{data_reg[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lane;
                wdata = {2{data_reg[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = data_reg;
            end
        endcase
        ram_we = (state_reg == WR) && ram_hit && !misaligned;
    end

    // Four byte-wide RAM lanes, so each lane can be written on its own.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [RAM_WORDS];

            // Lane write. There is no reset, so the contents survive rst.
            always_ff @(posedge clk) begin
                if (ram_we && be[gi]) begin
                    mem[word_idx] <= wdata[8*gi +: 8];
                end
            end

            assign rd_word[gi] = mem[word_idx];
        end
    endgenerate

    // Format the load result: align the lanes, extend, or read a register.
    always_comb begin
        shifted = 32'(rd_word) >> {lane, 3'b000};
        case (size_reg)
            2'b00:   load_data = {{24{sign_reg & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sign_reg & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase

        case (addr_reg[3:2])
            2'd0:    reg_rdata = {30'd0, status_reg};
            2'd1:    reg_rdata = fault_addr_reg;
            default: reg_rdata = 32'd0;
        endcase

        if (access_fault) begin
            rd_result = 32'd0;
        end else if (ram_hit) begin
            rd_result = load_data;
        end else begin
            rd_result = reg_rdata;
        end

        // Combine the sticky-bit set and the write-1-to-clear. A set wins.
        status_set = 2'b00;
        status_clr = 2'b00;
        if (state_reg != IDLE && access_fault) begin
            status_set = misaligned ? 2'b01 : 2'b10;
        end
        if (state_reg == WR && reg_hit && !misaligned && addr_reg[3:2] == 2'd0) begin
            status_clr = data_reg[1:0];
        end
        status_next = (status_reg & ~status_clr) | status_set;
    end

    // Control FSM. It accepts a request in IDLE and completes it on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'd0;
            data_reg       <= 32'd0;
            size_reg       <= 2'b00;
            sign_reg       <= 1'b0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            rvalid_reg     <= 1'b0;
            fault_reg      <= 1'b0;
            data_out_reg   <= 32'd0;
            status_reg     <= 2'b00;
            fault_addr_reg <= 32'd0;
        end else begin
            rvalid_reg   <= 1'b0;
            fault_reg    <= 1'b0;
            data_out_reg <= 32'd0;
            case (state_reg)
                IDLE: begin
                    if (bus.wd) begin
                        addr_reg  <= bus.addr_in;
                        size_reg  <= bus.size_in;
                        data_reg  <= bus.data_in;
                        sign_reg  <= 1'b0;
                        state_reg <= WR;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else if (bus.rd) begin
                        addr_reg  <= bus.addr_out;
                        size_reg  <= bus.size_out;
                        sign_reg  <= bus.sign_out;
                        state_reg <= RD;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                RD, WR: begin
                    if (state_reg == RD) begin
                        rvalid_reg   <= 1'b1;
                        data_out_reg <= rd_result;
                    end
                    fault_reg  <= access_fault;
                    status_reg <= status_next;
                    if (access_fault && status_reg == 2'b00) begin
                        fault_addr_reg <= addr_reg;
                    end
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.rvalid   = rvalid_reg;
    assign bus.ready    = ready_reg;
    assign bus.busy     = busy_reg;
    assign bus.fault    = fault_reg;
endmodule
